// File: rtl/usb_crc_tx_arbiter_pkg.sv
// usb_crc_arb_pkg: shared types and constants for the CRC16 TX arbiter
package usb_crc_arb_pkg;
  localparam int PKT_W = 100;
  localparam int LEN_W = 32;
  localparam int IW = 2;
  localparam logic [LEN_W-1:0] MIN_LEN = 9;
  localparam logic [LEN_W-1:0] MAX_LEN = 100;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, RELEASE} state_t;
endpackage

// File: rtl/usb_crc_tx_arbiter_if.sv
// usb_crc_tx_arbiter_if: requester and encoder signals of the CRC16 TX arbiter
interface usb_crc_tx_arbiter_if import usb_crc_arb_pkg::*; #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req, gnt, done, err;
  logic [NUM_REQ-1:0][PKT_W-1:0] req_pkt;
  logic [NUM_REQ-1:0][LEN_W-1:0] req_len;
  logic enc_start, enc_done, enc_abort;
  logic [PKT_W-1:0] enc_pkt;
  logic [LEN_W-1:0] enc_len;
  modport master (
    output req, req_pkt, req_len, enc_done,
    input  gnt, done, err, enc_start, enc_pkt, enc_len, enc_abort
  );
  modport slave (
    input  req, req_pkt, req_len, enc_done,
    output gnt, done, err, enc_start, enc_pkt, enc_len, enc_abort
  );
endinterface

// File: rtl/usb_crc_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requester at or after ptr
module rr_arbiter import usb_crc_arb_pkg::*; #(parameter int NUM_REQ = 2) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      for (int j = 0; j < NUM_REQ; j++)
        if (j == (int'(ptr) + i) % NUM_REQ && req[j]) begin
          win = '0;
          win[j] = 1'b1;
        end
  end
  assign valid = |req;
endmodule

// File: rtl/usb_crc_tx_arbiter.sv
// usb_crc_tx_arbiter: round-robin sequencer for the shared CRC16 TX encoder.
// The completion watchdog is built only when USB_CRC_ARB_WATCHDOG_EN is defined.
module usb_crc_tx_arbiter import usb_crc_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 512
) (
  input logic clock,
  input logic reset_n,
  usb_crc_tx_arbiter_if.slave bus
);
  state_t state, nxt;
  logic [NUM_REQ-1:0] win, gnt;
  logic any, len_ok, expire, err_flag;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [PKT_W-1:0] pkt, sel_pkt;
  logic [LEN_W-1:0] len, sel_len;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(bus.req), .ptr(rr_ptr), .win(win), .valid(any));

  assign len_ok = len >= MIN_LEN && len <= MAX_LEN;

  always_comb begin
    nxt = state;
    sel_pkt = '0;
    sel_len = '0;
    rr_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_pkt = bus.req_pkt[i];
        sel_len = bus.req_len[i];
      end
      if (gnt[i]) rr_nxt = (i == NUM_REQ - 1) ? '0 : IW'(i + 1);
    end
    case (state)
      IDLE:      nxt = any ? LOAD : IDLE;
      LOAD:      nxt = len_ok ? WAIT_DONE : RELEASE;
      WAIT_DONE: nxt = (bus.enc_done || expire) ? RELEASE : WAIT_DONE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      err_flag <= 1'b0;
      pkt <= '0;
      len <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        gnt <= win;
        pkt <= sel_pkt;
        len <= sel_len;
      end
      if ((state == LOAD && !len_ok) || expire) err_flag <= 1'b1;
      if (state == RELEASE) begin
        gnt <= '0;
        err_flag <= 1'b0;
        rr_ptr <= rr_nxt;
      end
    end
  end

`ifdef USB_CRC_ARB_WATCHDOG_EN
  logic [31:0] wd_cnt;
  always_ff @(posedge clock) wd_cnt <= (!reset_n || state != WAIT_DONE) ? '0 : wd_cnt + 32'd1;
  // a completion arriving on the expiry cycle wins over the abort
  assign expire = state == WAIT_DONE && !bus.enc_done && wd_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
`endif

  assign bus.gnt = gnt;
  assign bus.done = (state == RELEASE) ? gnt : '0;
  assign bus.err = (state == RELEASE && err_flag) ? gnt : '0;
  assign bus.enc_start = state == LOAD && len_ok;
  assign bus.enc_pkt = pkt;
  assign bus.enc_len = len;
  assign bus.enc_abort = expire;
endmodule

// File: tb/tb_usb_crc_tx_arbiter.sv
// tb_usb_crc_tx_arbiter: scoreboard bench for the CRC16 TX arbiter
module tb_usb_crc_tx_arbiter;
  import usb_crc_arb_pkg::*;
  typedef struct { logic [1:0] done; logic [1:0] err; } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0, n_fail = 0, n_start = 0, s0;
  exp_t exp_q[$];
  exp_t e;
  logic [PKT_W-1:0] p0, p1;

  usb_crc_tx_arbiter_if #(.NUM_REQ(2)) bus();
  usb_crc_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] er);
    exp_q.push_back('{d, er});
  endtask

  task automatic complete(input int wait_n, input logic [1:0] req_after);
    tick(wait_n);
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    bus.req = req_after;
    tick();
  endtask

  always @(negedge clock) if (reset_n) begin
    if (bus.enc_start) n_start++;
    if (bus.done != 2'b00) begin
      if (exp_q.size() == 0) chk("done_unexpected", bus.done, 0);
      else begin
        e = exp_q.pop_front();
        chk("done", bus.done, e.done);
        chk("err", bus.err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req = '0;
    bus.req_pkt = '0;
    bus.req_len = '0;
    bus.enc_done = 1'b0;
    p0 = PKT_W'({$urandom, $urandom, $urandom, $urandom});
    p1 = PKT_W'({$urandom, $urandom, $urandom, $urandom});
    tick(3);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_start", bus.enc_start, 0);
    chk("rst_abort", bus.enc_abort, 0);
    chk("rst_pkt", bus.enc_pkt, 0);
    chk("rst_len", bus.enc_len, 0);
    reset_n = 1'b1;
    tick();
    // contention from reset: 0 then 1, then 0 again after wrap
    bus.req_pkt[0] = p0;
    bus.req_pkt[1] = p1;
    bus.req_len[0] = 16;
    bus.req_len[1] = 20;
    bus.req = 2'b11;
    push(2'b01, 2'b00);
    push(2'b10, 2'b00);
    tick();
    chk("c_gnt0", bus.gnt, 2'b01);
    chk("c_start0", bus.enc_start, 1);
    chk("c_len0", bus.enc_len, 16);
    chk("c_pkt0", bus.enc_pkt, p0);
    complete(1, 2'b10);
    tick();
    chk("c_gnt1", bus.gnt, 2'b10);
    chk("c_start1", bus.enc_start, 1);
    chk("c_len1", bus.enc_len, 20);
    chk("c_pkt1", bus.enc_pkt, p1);
    complete(1, 2'b00);
    bus.req = 2'b11;
    push(2'b01, 2'b00);
    tick();
    chk("c_wrap", bus.gnt, 2'b01);
    complete(1, 2'b00);
    // single long transfer on requester 0
    bus.req_len[0] = 24;
    bus.req = 2'b01;
    push(2'b01, 2'b00);
    tick();
    chk("s_start", bus.enc_start, 1);
    chk("s_len", bus.enc_len, 24);
    tick();
    chk("s_wait_start", bus.enc_start, 0);
    chk("s_wait_gnt", bus.gnt, 2'b01);
    tick(38);
    chk("s_pkt_stable", bus.enc_pkt, p0);
    chk("s_abort", bus.enc_abort, 0);
    complete(1, 2'b00);
    chk("s_gnt_clr", bus.gnt, 0);
    // bad lengths on requester 1
    s0 = n_start;
    for (int k = 0; k < 2; k++) begin
      bus.req_len[1] = (k == 0) ? 8 : 101;
      bus.req = 2'b10;
      push(2'b10, 2'b10);
      tick();
      chk("bad_gnt", bus.gnt, 2'b10);
      chk("bad_start", bus.enc_start, 0);
      tick();
      chk("bad_done", bus.done, 2'b10);
      bus.req = 2'b00;
      tick();
    end
    chk("bad_nostart", n_start, s0);
    // boundary lengths 100 and 9
    bus.req_len[0] = 100;
    bus.req_len[1] = 9;
    bus.req = 2'b11;
    push(2'b01, 2'b00);
    push(2'b10, 2'b00);
    tick();
    chk("b_start100", bus.enc_start, 1);
    chk("b_gnt100", bus.gnt, 2'b01);
    complete(1, 2'b10);
    tick();
    chk("b_start9", bus.enc_start, 1);
    chk("b_len9", bus.enc_len, 9);
    complete(1, 2'b00);
    // stray enc_done in IDLE
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    tick();
    chk("stray_gnt", bus.gnt, 0);
    // request dropped during WAIT_DONE
    bus.req_len[0] = 50;
    bus.req = 2'b01;
    push(2'b01, 2'b00);
    tick(2);
    bus.req = 2'b00;
    complete(5, 2'b00);
    // reset while waiting; pointer (now 1) must return to 0
    bus.req = 2'b11;
    tick();
    chk("r_gnt_pre", bus.gnt, 2'b10);
    tick();
    reset_n = 1'b0;
    tick();
    chk("r_gnt", bus.gnt, 0);
    chk("r_len", bus.enc_len, 0);
    chk("r_pkt", bus.enc_pkt, 0);
    reset_n = 1'b1;
    push(2'b01, 2'b00);
    tick();
    chk("r_gnt_after", bus.gnt, 2'b01);
    complete(1, 2'b00);
`ifdef USB_CRC_ARB_WATCHDOG_EN
    bus.req_len[0] = 24;
    bus.req = 2'b01;
    push(2'b01, 2'b01);
    tick(2);
    tick(14);
    chk("wd_pre", bus.enc_abort, 0);
    tick();
    chk("wd_abort", bus.enc_abort, 1);
    bus.req = 2'b00;
    tick();
    chk("wd_done", bus.done, 2'b01);
    chk("wd_abort_clr", bus.enc_abort, 0);
    tick();
    bus.req = 2'b01;
    push(2'b01, 2'b00);
    tick(2);
    tick(15);
    bus.enc_done = 1'b1;
    #1;
    chk("wd_coinc_abort", bus.enc_abort, 0);
    tick();
    bus.enc_done = 1'b0;
    bus.req = 2'b00;
    chk("wd_coinc_done", bus.done, 2'b01);
    tick();
`endif
    tick(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_crc_tx_arbiter.md
# usb_crc_tx_arbiter

Sequencer and arbiter for the shared CRC16 transmit encoder. Several protocol-layer requesters (e.g. data-out channel, retry engine) each present a packet image and length; this block grants one at a time by round-robin, launches the encoder with a start pulse, waits for its completion, and returns a per-requester done/error. It sits between the protocol handler channels and the CRC16 encoder that feeds the bit stuffer.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- TIMEOUT_CYCLES, 512: watchdog limit in clocks, used only with the watchdog compiled in.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held until its done pulse.
- req_pkt  in  NUM_REQ x 100  packet image per requester, PID in bits [7:0].
- req_len  in  NUM_REQ x 32  packet length in bits, PID included.
- gnt  out  NUM_REQ  one-hot grant, registered.
- done  out  NUM_REQ  one-cycle completion pulse.
- err  out  NUM_REQ  qualifies done; 1 = rejected or aborted.
- enc_start  out  1  one-cycle launch pulse to encoder.
- enc_pkt  out  100  latched packet image to encoder.
- enc_len  out  32  latched length to encoder.
- enc_done  in  1  one-cycle pulse from encoder after last CRC bit.
- enc_abort  out  1  one-cycle pulse; encoder returns to idle (watchdog only).

## Operation
- States: IDLE, LOAD, WAIT_DONE, RELEASE.
- IDLE: when any req is high, a round-robin pick starts at pointer `rr_ptr` and chooses the lowest index at or after it. req_pkt/req_len of the winner are latched into enc_pkt/enc_len. gnt[winner] is set. Next state is LOAD.
- LOAD:
  - A length is valid when 9 ≤ len ≤ 100.
  - Valid: enc_start=1 for this cycle; next state WAIT_DONE.
  - Invalid: no enc_start; the error flag is set; next state RELEASE.
- WAIT_DONE: enc_done moves the block to RELEASE. Requester inputs are ignored; a req drop mid-transfer does not cancel it.
- RELEASE:
  - done[w]=1 and err[w]=error flag.
  - gnt clears on the next edge.
  - rr_ptr becomes (w+1) mod NUM_REQ.
  - The error flag clears.
  - Next state is IDLE.
- enc_done outside WAIT_DONE is ignored.
- Reset values:
  - gnt, done, err, enc_start and enc_abort are 0.
  - enc_pkt and enc_len are 0.
  - rr_ptr is 0; state is IDLE.
- Reset mid-transfer: all outputs return to reset values on the next edge. No done is issued for the interrupted request.

## Timing
- req sampled high in IDLE at cycle 0 gives gnt at cycle 1 and enc_start at cycle 1 (LOAD), if the length is valid.
- enc_done at cycle t gives done at t+1 and IDLE at t+2.
- A pending request then gets its next enc_start at t+3. Minimum overhead is 3 cycles between packets.
- Invalid length: req at cycle 0 gives done with err=1 at cycle 2. No encoder activity.
- enc_pkt and enc_len are stable from LOAD through RELEASE.

## Configuration
- USB_CRC_ARB_WATCHDOG_EN defined:
  - A 32-bit counter clears on entry to WAIT_DONE and increments each cycle in that state.
  - When the count reaches TIMEOUT_CYCLES-1 with no enc_done: enc_abort=1, the error flag is set, and the block goes to RELEASE.
  - enc_done in the same cycle as expiry takes priority: the transfer completes normally with no abort.
- Undefined: no counter is built; enc_abort is tied to 0; WAIT_DONE waits indefinitely.

## Structure
- Package usb_crc_arb_pkg holds:
  - the state enum;
  - PKT_W=100, LEN_W=32, MIN_LEN=9, MAX_LEN=100.
- One sub-module, rr_arbiter: takes req and rr_ptr and produces a one-hot winner plus a valid flag. It is combinational; the pointer register lives in the parent.

## Test plan
- Single request: req[0]=1, len=24. Expect enc_start at cycle 1 and enc_len=24. Encoder pulses enc_done 40 cycles later; done[0]=1, err[0]=0 one cycle after.
- Contention: req=2'b11 from reset. Requester 0 is served first, then requester 1. Then re-raise both; requester 0 wins again, because the pointer wrapped to 0 after serving requester 1.
- Bad length: req[1]=1 with len=8, then len=101. Each gives done[1]=1, err[1]=1 at cycle 2 and enc_start never asserts.
- Request drop: req[0] is dropped during WAIT_DONE. The transfer still completes with a done pulse.
- Watchdog (macro on, TIMEOUT_CYCLES=16): enc_done is withheld. enc_abort fires 16 cycles after entering WAIT_DONE, followed by done/err=1. Repeat with enc_done coincident with expiry: done only, no abort, err=0.
- Reset mid-operation: reset_n=0 during WAIT_DONE. gnt=0 and state IDLE next cycle, with no done pulse.
